// File: rtl/sseg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
// Segment and anode vectors are active-low throughout.
package sseg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode vector with only the selected digit driven low.
    function automatic logic [3:0] an_select_n(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/num2sseg.sv
// Nibble to active-low seven-segment decoder, segments a..g on o_sseg[6:0].
// Codes above 9 are not BCD and render as '0'.
module num2sseg (
    input  logic [3:0] i_num,
    output logic [6:0] o_sseg
);

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves o_sseg unassigned (no latch).
        o_sseg = 7'b0000001;
        case (i_num)
            4'd0: o_sseg = 7'b0000001;
            4'd1: o_sseg = 7'b1001111;
            4'd2: o_sseg = 7'b0010010;
            4'd3: o_sseg = 7'b0000110;
            4'd4: o_sseg = 7'b1001100;
            4'd5: o_sseg = 7'b0100100;
            4'd6: o_sseg = 7'b0100000;
            4'd7: o_sseg = 7'b0001111;
            4'd8: o_sseg = 7'b0000000;
            4'd9: o_sseg = 7'b0000100;
            default: o_sseg = 7'b0000001;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed driver for a four-digit common-anode BCD display.
// Optional leading-zero blanking is enabled by defining SSEG_LEADING_ZERO_BLANK_EN.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SLOT_HZ = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    dp
);

    localparam int               PRESCALE = CLK_HZ / SLOT_HZ;
    localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);

    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [CNT_W-1:0]        r_cnt;
    digit_idx_t              r_idx;

    logic       w_tick;
    digit_idx_t w_idx_next;
    logic [3:0] w_nibble;
    logic [6:0] w_seg;
    logic       w_blank;

    assign w_tick     = (r_cnt == CNT_MAX);
    assign w_idx_next = r_idx + 2'd1;
    // The shadow is read before this edge's load lands, so a colliding load shows from the next slot.
    assign w_nibble   = r_digits[{w_idx_next, 2'b00} +: 4];

    num2sseg u_dec (
        .i_num  (w_nibble),
        .o_sseg (w_seg)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit to its left are zero, unless its point is lit.
    always_comb begin
        w_blank = 1'b0;
        case (w_idx_next)
            2'd3:    w_blank = (r_digits[15:12] == 4'h0);
            2'd2:    w_blank = (r_digits[15:8]  == 8'h0);
            2'd1:    w_blank = (r_digits[15:4]  == 12'h0);
            default: w_blank = 1'b0;
        endcase
        if (r_dp_sh[w_idx_next])
            w_blank = 1'b0;
    end
`else
    assign w_blank = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits <= '0;
            r_dp_sh  <= '0;
            r_cnt    <= '0;
            r_idx    <= 2'd3;
            an       <= AN_OFF;
            sseg     <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            if (load) begin
                r_digits <= bcd_in;
                r_dp_sh  <= dp_in;
            end
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
                r_idx <= w_idx_next;
                if (!en) begin
                    an   <= AN_OFF;
                    sseg <= SEG_BLANK;
                    dp   <= 1'b1;
                end else begin
                    an   <= w_blank ? AN_OFF : an_select_n(w_idx_next);
                    sseg <= w_seg;
                    dp   <= ~r_dp_sh[w_idx_next];
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed self-checking bench for sseg_scan_driver at PRESCALE=4 (CLK_HZ=8, SLOT_HZ=2).
// Expectations for blanked slots follow SSEG_LEADING_ZERO_BLANK_EN when it is defined.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;

    int n_total = 0;
    int n_bad   = 0;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S9 = 7'b0000100;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .CLK_HZ  (8),
        .SLOT_HZ (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bcd_in (bcd_in),
        .dp_in  (dp_in),
        .en     (en),
        .an     (an),
        .sseg   (sseg),
        .dp     (dp)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        check("rst_an", 16'(an), 16'hF);
        check("rst_sseg", 16'(sseg), 16'h7F);
        check("rst_dp", 16'(dp), 16'h1);
        reset = 1'b0;
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        bcd_in = v;
        dp_in  = d;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    task automatic check_slot(input string tag, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp);
        check({tag, "_an"}, 16'(an), 16'(e_an));
        check({tag, "_sseg"}, 16'(sseg), 16'(e_seg));
        check({tag, "_dp"}, 16'(dp), 16'(e_dp));
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        en     = 1'b1;
        bcd_in = '0;
        dp_in  = '0;

        // Reset wins over a coincident load; scan order after release.
        bcd_in = 16'h1234;
        load   = 1'b1;
        do_reset();
        load   = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check($sformatf("pre_tick_an_%0d", i), 16'(an), 16'hF);
        end
        step(1);
        check_slot("scan0", 4'b1110, S0, 1'b1);
        step(4); check("scan1_an", 16'(an), 16'(4'b1101));
        step(4); check("scan2_an", 16'(an), 16'(4'b1011));
        step(4); check("scan3_an", 16'(an), 16'(4'b0111));
        step(4); check("scan4_an", 16'(an), 16'(4'b1110));

        // Decode 1234, reset arriving mid-slot.
        step(1);
        do_reset();
        load_val(16'h1234, 4'b0000);
        step(3); check_slot("dec_s0", 4'b1110, S4, 1'b1);
        step(4); check_slot("dec_s1", 4'b1101, S3, 1'b1);
        step(4); check_slot("dec_s2", 4'b1011, S2, 1'b1);
        step(4); check_slot("dec_s3", 4'b0111, S1, 1'b1);

        // Enable low blanks the next slot; the index keeps advancing.
        en = 1'b0;
        step(4); check_slot("en_off", 4'b1111, 7'b1111111, 1'b1);
        en = 1'b1;
        step(4); check_slot("en_on_s1", 4'b1101, S3, 1'b1);

        // Non-BCD nibble and decimal point.
        do_reset();
        load_val(16'h00F0, 4'b0010);
        step(3); check_slot("inv_s0", 4'b1110, S0, 1'b1);
        step(4); check_slot("inv_s1", 4'b1101, S0, 1'b0);
        step(4); check("inv_s2_an", 16'(an), BLANK_EN ? 16'hF : 16'(4'b1011));
        check("inv_s2_dp", 16'(dp), 16'h1);
        step(4); check("inv_s3_an", 16'(an), BLANK_EN ? 16'hF : 16'(4'b0111));
        check("inv_s3_dp", 16'(dp), 16'h1);

        // Load coincident with the tick into slot 0.
        do_reset();
        load_val(16'h0000, 4'b0000);
        step(2);
        bcd_in = 16'h9999;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
        check_slot("col_s0", 4'b1110, S0, 1'b1);
        step(4); check_slot("col_s1", 4'b1101, S9, 1'b1);
        step(4); check_slot("col_s2", 4'b1011, S9, 1'b1);

        // Leading-zero pattern 0050.
        do_reset();
        load_val(16'h0050, 4'b0000);
        step(3); check_slot("lz_s0", 4'b1110, S0, 1'b1);
        step(4); check_slot("lz_s1", 4'b1101, S5, 1'b1);
        step(4); check("lz_s2_an", 16'(an), BLANK_EN ? 16'hF : 16'(4'b1011));
        step(4); check("lz_s3_an", 16'(an), BLANK_EN ? 16'hF : 16'(4'b0111));

        // A lit decimal point keeps a leading zero visible.
        do_reset();
        load_val(16'h0050, 4'b1000);
        step(11); check("lzdp_s2_an", 16'(an), BLANK_EN ? 16'hF : 16'(4'b1011));
        step(4);  check_slot("lzdp_s3", 4'b0111, S0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
